// File: rtl/conv_output_stage.sv
// Convolution output stage: bias add, round-half-up requantization, optional ReLU,
// saturation, and an output FIFO with stall/overflow/saturation reporting.
module conv_output_stage #(
  parameter int IN_W       = 28,
  parameter int OUT_W      = 14,
  parameter int FRAC_SHIFT = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_sum,
  input  logic signed [OUT_W-1:0] bias,
  input  logic                    relu_en,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    stall,
  output logic                    overflow,
  output logic [7:0]              sat_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic signed [IN_W:0] A_MAX = {2'b00, {(IN_W-1){1'b1}}};
  localparam logic signed [IN_W:0] A_MIN = {2'b11, {(IN_W-1){1'b0}}};
  localparam logic signed [IN_W:0] B_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] B_MIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [IN_W:0] ROUND = (IN_W+1)'(1) << (FRAC_SHIFT - 1);

  // Pipeline registers
  logic                    va_q, vb_q;
  logic signed [IN_W-1:0]  sa_q;
  logic                    relu_a_q, sat_a_q;
  logic signed [OUT_W-1:0] rb_q;
  logic                    sat_b_q;

  // FIFO state
  logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic [7:0]       sat_count_q;

  // Stage A / B next-state
  logic signed [IN_W:0]    aligned, sum_a, rnd, shifted;
  logic signed [IN_W-1:0]  sa_d;
  logic                    sat_a_d, sat_b_d;
  logic signed [OUT_W-1:0] rb_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    aligned = {{(IN_W+1-OUT_W){bias[OUT_W-1]}}, bias};
    aligned = aligned <<< FRAC_SHIFT;
    sum_a   = {in_sum[IN_W-1], in_sum} + aligned;
    sat_a_d = 1'b0;
    sa_d    = sum_a[IN_W-1:0];
    if (sum_a > A_MAX) begin
      sa_d    = A_MAX[IN_W-1:0];
      sat_a_d = 1'b1;
    end else if (sum_a < A_MIN) begin
      sa_d    = A_MIN[IN_W-1:0];
      sat_a_d = 1'b1;
    end

    // One guard bit above IN_W keeps the rounding add from wrapping.
    rnd     = {sa_q[IN_W-1], sa_q} + ROUND;
    shifted = rnd >>> FRAC_SHIFT;
    if (relu_a_q && shifted < 0) shifted = '0;
    sat_b_d = 1'b0;
    rb_d    = shifted[OUT_W-1:0];
    if (shifted > B_MAX) begin
      rb_d    = B_MAX[OUT_W-1:0];
      sat_b_d = 1'b1;
    end else if (shifted < B_MIN) begin
      rb_d    = B_MIN[OUT_W-1:0];
      sat_b_d = 1'b1;
    end
  end

  logic full, pop, push_ok, drop;
  logic [CW:0] occupancy;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready;
  assign push_ok   = vb_q && (!full || pop);
  assign drop      = vb_q && full && !pop;
  assign occupancy = (CW+1)'(count_q) + (CW+1)'(va_q) + (CW+1)'(vb_q);
  assign stall     = (occupancy >= (CW+1)'(FIFO_DEPTH - 1));
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign overflow  = overflow_q;
  assign sat_count = sat_count_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      va_q        <= 1'b0;
      vb_q        <= 1'b0;
      sa_q        <= '0;
      relu_a_q    <= 1'b0;
      sat_a_q     <= 1'b0;
      rb_q        <= '0;
      sat_b_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      va_q     <= in_valid && !clear;
      sa_q     <= sa_d;
      relu_a_q <= relu_en;
      sat_a_q  <= sat_a_d;
      vb_q     <= va_q && !clear;
      rb_q     <= rb_d;
      sat_b_q  <= sat_a_q | sat_b_d;
      if (clear) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
        if (push_ok && !pop)      count_q <= count_q + CW'(1);
        else if (!push_ok && pop) count_q <= count_q - CW'(1);
        if (drop) overflow_q <= 1'b1;
        if (vb_q && sat_b_q && sat_count_q != 8'hFF) sat_count_q <= sat_count_q + 8'd1;
      end
    end
  end

  // NOTE: FIFO storage is not reset; out_data is gated by out_valid so stale entries never escape.
  always_ff @(posedge clk) begin
    if (!reset && !clear && push_ok) mem_q[wr_ptr_q] <= rb_q;
  end

endmodule
